// File: rtl/whack_pkg.sv
// Shared encodings and LFSR constants for the whack-a-mole game blocks.
package whack_pkg;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_GAP   = 2'd1,
    S_UP    = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Right-shifting Galois step for taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Galois LFSR; shared by game logic and later effects blocks.
module whack_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: random mole selection, up/gap timing,
// scoring, miss limit and round limit for NUM_MOLES holes.
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int          NUM_MOLES  = 4,
  parameter int          MOLE_TICKS = 25_000_000,
  parameter int          GAP_TICKS  = 12_500_000,
  parameter int          ROUNDS     = 16,
  parameter int          MAX_MISSES = 3,
  parameter int          SCORE_W    = 8,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF,
  localparam int         IDX_W      = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_btn,
  input  logic [NUM_MOLES-1:0] hit,
  output logic [1:0]           state,
  output logic [3:0]           state_led,
  output logic [NUM_MOLES-1:0] mole_up,
  output logic [IDX_W-1:0]     mole_idx,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [SCORE_W-1:0]   round_cnt,
  output logic                 game_over
);

  localparam int TICK_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TIM_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TIM_W-1:0]   GAP_LOAD  = TIM_W'(GAP_TICKS - 1);
  localparam logic [TIM_W-1:0]   MOLE_LOAD = TIM_W'(MOLE_TICKS - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_MOLES - 1);
  localparam logic [SCORE_W-1:0] MISS_LIM  = SCORE_W'(MAX_MISSES);
  localparam logic [SCORE_W-1:0] RND_LIM   = SCORE_W'(ROUNDS);

  state_e                 state_q, state_d;
  logic [NUM_MOLES-1:0]   mole_up_q, mole_up_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [SCORE_W-1:0]     misses_q, misses_d;
  logic [SCORE_W-1:0]     round_q, round_d;
  logic [TIM_W-1:0]       timer_q, timer_d;
  logic                   over_q, over_d;
  logic                   start_q;
  logic [NUM_MOLES-1:0]   hit_q;

  logic [15:0]            lfsr;
  logic                   start_rise;
  logic [NUM_MOLES-1:0]   hit_rise;
  logic [IDX_W-1:0]       cand, sel;
  logic [SCORE_W-1:0]     miss_inc, round_inc, score_sat;

  whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign start_rise = start_btn & ~start_q;
  assign hit_rise   = hit & ~hit_q;

  // Bump a candidate that matches the previous mole so no hole repeats back to back.
  assign cand = IDX_W'({16'd0, lfsr} % 32'(NUM_MOLES));
  assign sel  = (cand != idx_q) ? cand :
                (cand == IDX_LAST) ? '0 : cand + IDX_W'(1);

  assign miss_inc  = misses_q + SCORE_W'(1);
  assign round_inc = round_q + SCORE_W'(1);
  assign score_sat = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);

  always_comb begin
    state_d   = state_q;
    mole_up_d = mole_up_q;
    idx_d     = idx_q;
    score_d   = score_q;
    misses_d  = misses_q;
    round_d   = round_q;
    timer_d   = timer_q;
    over_d    = over_q;
    unique case (state_q)
      S_START, S_OVER: begin
        if (start_rise) begin
          state_d  = S_GAP;
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
          timer_d  = GAP_LOAD;
          over_d   = 1'b0;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d   = S_UP;
          idx_d     = sel;
          mole_up_d = NUM_MOLES'(1) << sel;
          timer_d   = MOLE_LOAD;
        end else begin
          timer_d = timer_q - TIM_W'(1);
        end
      end
      S_UP: begin
        if (hit_rise[idx_q]) begin
          score_d   = score_sat;
          round_d   = round_inc;
          mole_up_d = '0;
          if (round_inc == RND_LIM) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            timer_d = GAP_LOAD;
          end
        end else if (|hit_rise) begin
          misses_d = miss_inc;
          if (miss_inc == MISS_LIM) begin
            state_d   = S_OVER;
            over_d    = 1'b1;
            mole_up_d = '0;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TIM_W'(1);
          end
        end else if (timer_q == '0) begin
          misses_d  = miss_inc;
          round_d   = round_inc;
          mole_up_d = '0;
          if (miss_inc == MISS_LIM || round_inc == RND_LIM) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            timer_d = GAP_LOAD;
          end
        end else begin
          timer_d = timer_q - TIM_W'(1);
        end
      end
    endcase
  end

  // Edge registers reset high so buttons held through reset release are not seen as presses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_START;
      mole_up_q <= '0;
      idx_q     <= '0;
      score_q   <= '0;
      misses_q  <= '0;
      round_q   <= '0;
      timer_q   <= '0;
      over_q    <= 1'b0;
      start_q   <= 1'b1;
      hit_q     <= '1;
    end else begin
      state_q   <= state_d;
      mole_up_q <= mole_up_d;
      idx_q     <= idx_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      round_q   <= round_d;
      timer_q   <= timer_d;
      over_q    <= over_d;
      start_q   <= start_btn;
      hit_q     <= hit;
    end
  end

  assign state     = state_q;
  assign state_led = 4'b0001 << state_q;
  assign mole_up   = mole_up_q;
  assign mole_idx  = idx_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign round_cnt = round_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: 4-hole and 5-hole instances checked every cycle against a game model.
module tb_whack_game_ctrl;

  localparam int MOLE = 8;
  localparam int GAP  = 4;
  localparam int RND  = 3;
  localparam int MAXM = 2;
  localparam int P_START = 0, P_GAP = 1, P_UP = 2, P_OVER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_btn;
  logic [3:0] hit4;
  logic [4:0] hit5;
  logic [1:0] st4, st5;
  logic [3:0] led4, led5;
  logic [3:0] up4;
  logic [4:0] up5;
  logic [1:0] idx4;
  logic [2:0] idx5;
  logic [7:0] sc4, sc5, mi4, mi5, rc4, rc5;
  logic       go4, go5;

  whack_game_ctrl #(.NUM_MOLES(4), .MOLE_TICKS(MOLE), .GAP_TICKS(GAP), .ROUNDS(RND),
                    .MAX_MISSES(MAXM), .SCORE_W(8), .LFSR_SEED(16'hACE1)) dut4 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .hit(hit4),
    .state(st4), .state_led(led4), .mole_up(up4), .mole_idx(idx4),
    .score(sc4), .misses(mi4), .round_cnt(rc4), .game_over(go4));

  whack_game_ctrl #(.NUM_MOLES(5), .MOLE_TICKS(MOLE), .GAP_TICKS(GAP), .ROUNDS(RND),
                    .MAX_MISSES(MAXM), .SCORE_W(8), .LFSR_SEED(16'hACE1)) dut5 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .hit(hit5),
    .state(st5), .state_led(led5), .mole_up(up5), .mole_idx(idx5),
    .score(sc5), .misses(mi5), .round_cnt(rc5), .game_over(go5));

  // Game model, one slot per instance.
  int          nm [2] = '{4, 5};
  int          ph [2];
  int          el [2];
  logic [15:0] lf [2];
  int          mid[2];
  int          mup[2];
  int          msc[2], mmi[2], mrc[2];
  int          mov[2];
  int          pst[2];
  int          phit[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic model_step(input int k, input int r, input int s, input int h);
    int hm, hr, sr, cand, sel, leave;
    if (r != 0) begin
      ph[k] = P_START; el[k] = 0; lf[k] = 16'hACE1; mid[k] = 0; mup[k] = 0;
      msc[k] = 0; mmi[k] = 0; mrc[k] = 0; mov[k] = 0;
      pst[k] = 1; phit[k] = (1 << nm[k]) - 1;
    end else begin
      hm    = h & ((1 << nm[k]) - 1);
      hr    = hm & ~phit[k];
      sr    = (s != 0 && pst[k] == 0) ? 1 : 0;
      cand  = int'(lf[k]) % nm[k];
      sel   = (cand == mid[k]) ? (cand + 1) % nm[k] : cand;
      leave = 0;
      case (ph[k])
        P_START, P_OVER: if (sr != 0) begin
          ph[k] = P_GAP; el[k] = 0; msc[k] = 0; mmi[k] = 0; mrc[k] = 0; mov[k] = 0;
        end
        P_GAP: if (el[k] == GAP - 1) begin
          ph[k] = P_UP; mid[k] = sel; mup[k] = 1 << sel; el[k] = 0;
        end else el[k]++;
        P_UP: begin
          if (((hr >> mid[k]) & 1) != 0) begin
            if (msc[k] < 255) msc[k]++;
            mrc[k]++; mup[k] = 0; leave = 1;
          end else if (hr != 0) begin
            mmi[k]++;
            if (mmi[k] == MAXM) begin
              mup[k] = 0; ph[k] = P_OVER; mov[k] = 1;
            end else if (el[k] < MOLE - 1) el[k]++;
          end else if (el[k] == MOLE - 1) begin
            mmi[k]++; mrc[k]++; mup[k] = 0; leave = 1;
          end else el[k]++;
          if (leave != 0) begin
            if (mmi[k] == MAXM || mrc[k] == RND) begin
              ph[k] = P_OVER; mov[k] = 1;
            end else begin
              ph[k] = P_GAP; el[k] = 0;
            end
          end
        end
        default: ;
      endcase
      lf[k]   = lf[k][0] ? ((lf[k] >> 1) ^ 16'hB400) : (lf[k] >> 1);
      pst[k]  = s;
      phit[k] = hm;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state4", 32'(st4), ph[0]);
    chk("led4", 32'(led4), 1 << ph[0]);
    chk("mole_up4", 32'(up4), mup[0]);
    chk("mole_idx4", 32'(idx4), mid[0]);
    chk("score4", 32'(sc4), msc[0]);
    chk("misses4", 32'(mi4), mmi[0]);
    chk("round4", 32'(rc4), mrc[0]);
    chk("over4", 32'(go4), mov[0]);
    chk("state5", 32'(st5), ph[1]);
    chk("led5", 32'(led5), 1 << ph[1]);
    chk("mole_up5", 32'(up5), mup[1]);
    chk("mole_idx5", 32'(idx5), mid[1]);
    chk("score5", 32'(sc5), msc[1]);
    chk("misses5", 32'(mi5), mmi[1]);
    chk("round5", 32'(rc5), mrc[1]);
    chk("over5", 32'(go5), mov[1]);
    chk("idx5_range", 32'(idx5 < 3'd5), 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, int'(reset), int'(start_btn), int'(hit4));
    model_step(1, int'(reset), int'(start_btn), int'(hit5));
    #1;
    compare_all();
  endtask

  task automatic wait_up();
    int p4, p5;
    p4 = mid[0];
    p5 = mid[1];
    for (int i = 0; i < 20 && ph[0] != P_UP; i++) step();
    chk("reach_up", 32'(st4), P_UP);
    chk("norepeat4", 32'(int'(idx4) != p4), 1);
    chk("norepeat5", 32'(int'(idx5) != p5), 1);
  endtask

  task automatic run_out_up();
    for (int i = 0; i < 20 && ph[0] == P_UP; i++) step();
    chk("left_up", 32'(st4 != 2'd2), 1);
  endtask

  task automatic whack(input int with_wrong);
    hit4 = 4'(1 << mid[0]);
    hit5 = 5'(1 << mid[1]);
    if (with_wrong != 0) begin
      hit4 = hit4 | 4'(1 << ((mid[0] + 1) % 4));
      hit5 = hit5 | 5'(1 << ((mid[1] + 1) % 5));
    end
    step();
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b1; hit4 = 4'b0100; hit5 = 5'b00100;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    chk("rst_state", 32'(st4), 0);
    chk("rst_led", 32'(led4), 1);
    chk("rst_score", 32'(sc4), 0);
    start_btn = 1'b0; hit4 = '0; hit5 = '0;
    step();

    start_btn = 1'b1; step();
    chk("start_gap", 32'(st4), P_GAP);
    start_btn = 1'b0;
    wait_up();
    chk("onehot4", 32'(up4), 32'(1) << idx4);

    whack(1);
    chk("both_score", 32'(sc4), 1);
    chk("both_miss", 32'(mi4), 0);
    chk("both_round", 32'(rc4), 1);
    chk("both_up", 32'(up4), 0);
    chk("both_state", 32'(st5), P_GAP);
    hit4 = '0; hit5 = '0;
    wait_up(); run_out_up();
    wait_up(); run_out_up();
    chk("miss_out", 32'(mi4), 2);
    chk("miss_over", 32'(st4), P_OVER);
    chk("miss_led", 32'(led5), 8);
    chk("miss_go", 32'(go5), 1);

    start_btn = 1'b1; step();
    start_btn = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_up();
      whack(0);
      hit4 = '0; hit5 = '0;
      step();
    end
    chk("win_score", 32'(sc4), 3);
    chk("win_round", 32'(rc5), 3);
    chk("win_state", 32'(st4), P_OVER);
    hit4 = 4'hF; hit5 = 5'h1F; step();
    hit4 = '0; hit5 = '0; step();
    chk("over_hold", 32'(sc5), 3);
    start_btn = 1'b1; step();
    start_btn = 1'b0;
    chk("restart_state", 32'(st4), P_GAP);
    chk("restart_score", 32'(sc4), 0);

    wait_up();
    reset = 1'b1; step();
    chk("abort_state", 32'(st4), P_START);
    chk("abort_up", 32'(up5), 0);
    reset = 1'b0; step();

    for (int i = 0; i < 800; i++) begin
      start_btn = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      case ($urandom_range(0, 5))
        0: begin hit4 = 4'($urandom_range(0, 15)); hit5 = 5'($urandom_range(0, 31)); end
        1: begin hit4 = 4'(1 << mid[0]); hit5 = 5'(1 << mid[1]); end
        default: begin hit4 = '0; hit5 = '0; end
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
